// File: rtl/random_gen.sv
// Free-running Galois LFSR that supplies a pseudo-random victim block index
// to the cache controller's random-replacement path.
module random_gen #(
  parameter int                OUT_W  = 4,
  parameter int                LFSR_W = 32,
  parameter logic [LFSR_W-1:0] TAPS   = 32'hA300_0000,
  parameter logic [LFSR_W-1:0] SEED   = 32'hACE1_2345
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [OUT_W-1:0] rand_out
);

  // An all-zero state would lock the LFSR, so a zero seed is replaced by 1.
  localparam logic [LFSR_W-1:0] RESET_VAL =
    (SEED == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : SEED;

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q == '0) begin
      lfsr_d = RESET_VAL;
    end else if (lfsr_q[0]) begin
      lfsr_d = (lfsr_q >> 1) ^ TAPS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= RESET_VAL;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign rand_out = lfsr_q[OUT_W-1:0];

endmodule

// File: tb/tb_random_gen.sv
// Directed bench for random_gen: default instance, zero-seed instance and a
// 3-bit output instance all share one clock and reset.
module tb_random_gen;

  logic       clk;
  logic       rst_n;
  logic [3:0] rand_out;
  logic [3:0] rand_out_z;
  logic [2:0] rand_out_3;

  int compared;
  int mismatched;

  random_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rand_out (rand_out)
  );

  random_gen #(.SEED(32'h0000_0000)) dut_zero (
    .clk      (clk),
    .rst_n    (rst_n),
    .rand_out (rand_out_z)
  );

  random_gen #(.OUT_W(3)) dut_w3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .rand_out (rand_out_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp_state;
    logic [3:0]  exp_out;
    logic [2:0]  exp_out3;
  } step_vec_t;

  step_vec_t vecs[3];

  function automatic logic [31:0] modelStep(input logic [31:0] s);
    logic [31:0] n;
    if (s == 32'h0) begin
      n = 32'hACE1_2345;
    end else if (s[0]) begin
      n = (s >> 1) ^ 32'hA300_0000;
    end else begin
      n = s >> 1;
    end
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int edges);
    for (int i = 0; i < edges; i++) begin
      @(posedge clk);
    end
    #1;
  endtask

  task automatic holdAndRelease();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_async_out", {28'h0, rand_out}, 32'h5);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("reset_hold_out_%0d", i), {28'h0, rand_out}, 32'h5);
      checkOutput($sformatf("reset_hold_state_%0d", i), dut.lfsr_q, 32'hACE1_2345);
    end
    checkOutput("reset_zero_seed_state", dut_zero.lfsr_q, 32'h0000_0001);
    checkOutput("reset_w3_out", {29'h0, rand_out_3}, 32'h5);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic runFirstSteps(input string tag);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      checkOutput({tag, "_", vecs[i].name, "_state"}, dut.lfsr_q, vecs[i].exp_state);
      checkOutput({tag, "_", vecs[i].name, "_out"}, {28'h0, rand_out},
                  {28'h0, vecs[i].exp_out});
      checkOutput({tag, "_", vecs[i].name, "_w3"}, {29'h0, rand_out_3},
                  {29'h0, vecs[i].exp_out3});
    end
  endtask

  initial begin
    int          counts[16];
    int          seqErrs;
    int          zeroHits;
    logic [31:0] model;

    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b1;

    vecs[0] = '{name: "step1", exp_state: 32'hF570_91A2, exp_out: 4'd2, exp_out3: 3'd2};
    vecs[1] = '{name: "step2", exp_state: 32'h7AB8_48D1, exp_out: 4'd1, exp_out3: 3'd1};
    vecs[2] = '{name: "step3", exp_state: 32'h9E5C_2468, exp_out: 4'd8, exp_out3: 3'd0};

    $display("[TB] reset and first steps");
    holdAndRelease();
    applyStimulus(1);
    checkOutput("first_step_state", dut.lfsr_q, vecs[0].exp_state);
    checkOutput("zero_seed_edge1_state", dut_zero.lfsr_q, 32'hA300_0000);
    checkOutput("zero_seed_edge1_out", {28'h0, rand_out_z}, 32'h0);
    applyStimulus(1);
    checkOutput("zero_seed_edge2_state", dut_zero.lfsr_q, 32'h5180_0000);

    $display("[TB] table-driven first steps after fresh reset");
    holdAndRelease();
    runFirstSteps("run1");

    $display("[TB] mid-run asynchronous reset");
    applyStimulus(100);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrun_async_out", {28'h0, rand_out}, 32'h5);
    checkOutput("midrun_async_state", dut.lfsr_q, 32'hACE1_2345);
    @(negedge clk);
    rst_n = 1'b1;
    runFirstSteps("run2");

    $display("[TB] coverage run");
    for (int v = 0; v < 16; v++) counts[v] = 0;
    seqErrs  = 0;
    zeroHits = 0;
    model    = dut.lfsr_q;
    for (int c = 0; c < 10000; c++) begin
      applyStimulus(1);
      model = modelStep(model);
      if (dut.lfsr_q !== model) seqErrs++;
      if (dut.lfsr_q == 32'h0) zeroHits++;
      if (^rand_out !== 1'bx) counts[rand_out]++;
    end
    checkOutput("cov_sequence_errors", seqErrs, 0);
    checkOutput("cov_zero_state_hits", zeroHits, 0);
    for (int v = 0; v < 16; v++) begin
      compared++;
      if (counts[v] < 500 || counts[v] > 750) begin
        mismatched++;
        $display("[TB] FAIL cov_bin_%0d: count %0d, expected 500..750", v, counts[v]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
